// File: rtl/ray_dir_gen_if.sv
// Output stream of ray_dir_gen: one camera-ray direction per beat, tagged with its pixel position.
// The generator drives the master side and the downstream consumer drives the slave side.
interface ray_dir_gen_if;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] dir_x;
    logic [31:0] dir_y;
    logic [31:0] dir_z;
    logic [15:0] hcount_out;
    logic [15:0] vcount_out;

    modport master (
        input  ready_in,
        output valid_out, dir_x, dir_y, dir_z, hcount_out, vcount_out
    );

    modport slave (
        output ready_in,
        input  valid_out, dir_x, dir_y, dir_z, hcount_out, vcount_out
    );
endinterface

// File: rtl/ray_dir_gen.sv
// Raster-scan camera-ray generator.
// Emits (h - WIDTH/2, HEIGHT/2 - v, -FOCAL) as float32 words through a 3-stage stallable pipeline.
module ray_dir_gen #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 180,
    parameter int FOCAL  = 256
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    output logic          busy_out,
    output logic          done_out,
    ray_dir_gen_if.master out_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [15:0]        H_LAST = 16'(WIDTH - 1);
    localparam logic [15:0]        V_LAST = 16'(HEIGHT - 1);
    localparam logic signed [16:0] H_HALF = 17'(WIDTH / 2);
    localparam logic signed [16:0] V_HALF = 17'(HEIGHT / 2);
    localparam logic signed [16:0] Z_INT  = -17'(FOCAL);

    // Exact signed-integer to float32; |n| <= 32768 always fits the 24-bit significand.
    function automatic logic [31:0] int_to_f32(input logic signed [16:0] n);
        logic [16:0] mag;
        logic [4:0]  msb;
        logic [23:0] norm;
        logic [7:0]  expo;
        logic [31:0] word;
        mag = n[16] ? 17'(-n) : 17'(n);
        msb = '0;
        for (int i = 0; i < 17; i++) begin
            if (mag[i]) msb = 5'(i);
        end
        expo = 8'd127 + {3'b000, msb};
        norm = {7'b0000000, mag} << (5'd23 - msb);
        if (mag == '0) word = '0;
        else           word = {n[16], expo, norm[22:0]};
        return word;
    endfunction

    localparam logic [31:0] Z_WORD = int_to_f32(Z_INT);

    state_t state;
    state_t state_nxt;

    logic [15:0]        h_cnt;
    logic [15:0]        v_cnt;
    logic signed [16:0] s0_x;
    logic signed [16:0] s0_y;

    logic               s1_valid;
    logic [31:0]        s1_x;
    logic [31:0]        s1_y;
    logic [15:0]        s1_h;
    logic [15:0]        s1_v;

    logic               advance;
    logic               issue;
    logic               last_pix;
    logic               last_xfer;

    // A single global stall: every stage moves only when the output slot can take a new beat.
    assign advance   = out_if.ready_in | ~out_if.valid_out;
    assign issue     = advance && (state == S_RUN);
    assign last_pix  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign last_xfer = (state == S_DRAIN) && !s1_valid && out_if.valid_out && out_if.ready_in;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: defaults are assigned first so no path through the block leaves an output unassigned (no latch).
    always_comb begin
        state_nxt = state;
        busy_out  = 1'b1;
        case (state)
            S_IDLE: begin
                busy_out = 1'b0;
                if (start_in) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (issue && last_pix) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_xfer) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_out  = 1'b0;
            end
        endcase
    end

    // Stage 0: the pixel counters hold the next pixel to issue; the last pixel parks them.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (start_in) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end
        end else if (issue && !last_pix) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= v_cnt + 16'd1;
            end else begin
                h_cnt <= h_cnt + 16'd1;
            end
        end
    end

    assign s0_x = $signed({1'b0, h_cnt}) - H_HALF;
    assign s0_y = V_HALF - $signed({1'b0, v_cnt});

    // Stage 1: leading-one detect and normalize into float32 words.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_h     <= '0;
            s1_v     <= '0;
        end else if (advance) begin
            s1_valid <= issue;
            if (issue) begin
                s1_x <= int_to_f32(s0_x);
                s1_y <= int_to_f32(s0_y);
                s1_h <= h_cnt;
                s1_v <= v_cnt;
            end
        end
    end

    // Stage 2: output register; held whole while the consumer stalls.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            out_if.valid_out  <= 1'b0;
            out_if.dir_x      <= '0;
            out_if.dir_y      <= '0;
            out_if.dir_z      <= '0;
            out_if.hcount_out <= '0;
            out_if.vcount_out <= '0;
        end else if (advance) begin
            out_if.valid_out <= s1_valid;
            if (s1_valid) begin
                out_if.dir_x      <= s1_x;
                out_if.dir_y      <= s1_y;
                out_if.dir_z      <= Z_WORD;
                out_if.hcount_out <= s1_h;
                out_if.vcount_out <= s1_v;
            end
        end
    end

    // The done pulse follows the edge that accepted the final beat.
    always_ff @(posedge clk_in) begin
        if (!rst_in) done_out <= 1'b0;
        else         done_out <= last_xfer;
    end

endmodule

// File: tb/tb_ray_dir_gen.sv
// Self-checking bench for ray_dir_gen: a full default-size frame plus a 4x2 instance under stalls,
// held start and mid-scan reset, checked against an arithmetic reference model.
module tb_ray_dir_gen;

    localparam int BW = 320;
    localparam int BH = 180;
    localparam int BF = 256;
    localparam int SW = 4;
    localparam int SH = 2;
    localparam int SF = 1;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } beat_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_b, start_b, busy_b, done_b;
    logic rst_s, start_s, busy_s, done_s;

    ray_dir_gen_if if_b ();
    ray_dir_gen_if if_s ();

    ray_dir_gen #(.WIDTH(BW), .HEIGHT(BH), .FOCAL(BF)) dut_big (
        .clk_in   (clk_in),
        .rst_in   (rst_b),
        .start_in (start_b),
        .busy_out (busy_b),
        .done_out (done_b),
        .out_if   (if_b)
    );

    ray_dir_gen #(.WIDTH(SW), .HEIGHT(SH), .FOCAL(SF)) dut_small (
        .clk_in   (clk_in),
        .rst_in   (rst_s),
        .start_in (start_s),
        .busy_out (busy_s),
        .done_out (done_s),
        .out_if   (if_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    c_first_valid, c_first_xfer, c_last_xfer, c_done_cnt, c_done_cyc;
    int    c_stall_viol, c_busy_bad;
    bit    c_timeout;

    // Reference float32 of an integer, taken from the host double-precision encoding.
    function automatic logic [31:0] f32_ref(input int n);
        logic [63:0] d;
        if (n == 0) return 32'h0000_0000;
        d = $realtobits(real'(n));
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic beat_t exp_beat(input int h, input int v, input int w, input int ht, input int f);
        beat_t b;
        b.h = 16'(h);
        b.v = 16'(v);
        b.x = f32_ref(h - w / 2);
        b.y = f32_ref(ht / 2 - v);
        b.z = f32_ref(-f);
        return b;
    endfunction

    task automatic build_small_exp();
        exp_q.delete();
        for (int v = 0; v < SH; v++)
            for (int h = 0; h < SW; h++)
                exp_q.push_back(exp_beat(h, v, SW, SH, SF));
    endtask

    // Runs one scan of the small instance from IDLE and records what it observes.
    // mode 0: ready always high; 1: random ready with a 5-cycle hold; 2: ready low for the first 8 cycles.
    task automatic collect_small(input int mode, input bit hold_start, input int max_cycles);
        beat_t cur;
        beat_t prev;
        bit    prev_stall;
        bit    hold_used;
        bit    finished;
        int    hold_left;
        int    post;
        int    cyc;
        got_q.delete();
        c_first_valid = -1; c_first_xfer = -1; c_last_xfer = -1;
        c_done_cnt = 0; c_done_cyc = -1; c_stall_viol = 0; c_busy_bad = 0; c_timeout = 1'b0;
        prev = '0; prev_stall = 1'b0; hold_used = 1'b0; finished = 1'b0;
        hold_left = 0; post = 0; cyc = 0;
        start_s = 1'b1;
        if_s.ready_in = (mode == 2) ? 1'b0 : 1'b1;
        while (!finished) begin
            @(negedge clk_in);
            cyc++;
            cur = {if_s.hcount_out, if_s.vcount_out, if_s.dir_x, if_s.dir_y, if_s.dir_z};
            if (prev_stall && (!if_s.valid_out || cur != prev)) c_stall_viol++;
            if (if_s.valid_out && c_first_valid < 0) c_first_valid = cyc - 1;
            if (c_done_cyc < 0 && !done_s && !busy_s) c_busy_bad++;
            if (done_s) begin
                c_done_cnt++;
                c_done_cyc = cyc;
                if (busy_s) c_busy_bad++;
                start_s = 1'b0;
            end
            if (!hold_start) start_s = 1'b0;
            case (mode)
                1: begin
                    if (hold_left > 0) begin
                        if_s.ready_in = 1'b0;
                        hold_left--;
                    end else if (!hold_used && got_q.size() == 3 && if_s.valid_out) begin
                        hold_used = 1'b1;
                        hold_left = 4;
                        if_s.ready_in = 1'b0;
                    end else begin
                        if_s.ready_in = 1'($urandom_range(0, 1));
                    end
                end
                2:       if_s.ready_in = (cyc >= 8);
                default: if_s.ready_in = 1'b1;
            endcase
            if (if_s.valid_out && if_s.ready_in) begin
                got_q.push_back(cur);
                if (c_first_xfer < 0) c_first_xfer = cyc;
                c_last_xfer = cyc;
            end
            prev_stall = if_s.valid_out && !if_s.ready_in;
            prev = cur;
            if (c_done_cyc >= 0) post++;
            if (post > 4) finished = 1'b1;
            if (cyc >= max_cycles) begin
                c_timeout = 1'b1;
                finished = 1'b1;
            end
        end
        start_s = 1'b0;
        if_s.ready_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; rst_s = 1'b0;
        start_b = 1'b0; start_s = 1'b0;
        if_b.ready_in = 1'b1; if_s.ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_cmp++;
        if ({if_b.valid_out, busy_b, done_b, if_b.dir_x, if_b.dir_y, if_b.dir_z, if_b.hcount_out, if_b.vcount_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_big: valid=%b busy=%b done=%b x=%h y=%h z=%h h=%0d v=%0d, want all zero",
                     if_b.valid_out, busy_b, done_b, if_b.dir_x, if_b.dir_y, if_b.dir_z, if_b.hcount_out, if_b.vcount_out);
        end
        n_cmp++;
        if ({if_s.valid_out, busy_s, done_s, if_s.dir_x, if_s.dir_y, if_s.dir_z, if_s.hcount_out, if_s.vcount_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_small: valid=%b busy=%b done=%b x=%h y=%h z=%h h=%0d v=%0d, want all zero",
                     if_s.valid_out, busy_s, done_s, if_s.dir_x, if_s.dir_y, if_s.dir_z, if_s.hcount_out, if_s.vcount_out);
        end
        rst_b = 1'b1; rst_s = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_default_frame();
        beat_t cur;
        beat_t exp;
        int    cyc = 0;
        int    nbeat = 0;
        int    done_cnt = 0;
        int    done_cyc = -1;
        int    last_cyc = -1;
        int    post = 0;
        start_b = 1'b1;
        if_b.ready_in = 1'b1;
        while (post < 4 && cyc < 60000) begin
            @(negedge clk_in);
            cyc++;
            start_b = 1'b0;
            if (done_b) begin
                done_cnt++;
                done_cyc = cyc;
                n_cmp++;
                if (busy_b !== 1'b0) begin
                    n_bad++;
                    $display("FAIL big_busy_at_done: busy=%b, want 0", busy_b);
                end
            end
            if (done_cyc >= 0) post++;
            if (if_b.valid_out) begin
                cur = {if_b.hcount_out, if_b.vcount_out, if_b.dir_x, if_b.dir_y, if_b.dir_z};
                exp = exp_beat(nbeat % BW, nbeat / BW, BW, BH, BF);
                n_cmp++;
                if (cur !== exp) begin
                    n_bad++;
                    $display("FAIL big_beat[%0d]: got %h, want %h", nbeat, cur, exp);
                end
                if (nbeat == 0) begin
                    n_cmp++;
                    if (cyc - 1 != 2 || {cur.x, cur.y, cur.z} !== {32'hC320_0000, 32'h42B4_0000, 32'hC380_0000}) begin
                        n_bad++;
                        $display("FAIL big_first: latency=%0d xyz=%h, want latency 2 xyz C320000042B40000C3800000", cyc - 1, {cur.x, cur.y, cur.z});
                    end
                end
                if (nbeat == 160) begin
                    n_cmp++;
                    if (cur.h !== 16'd160 || cur.x !== 32'h0000_0000) begin
                        n_bad++;
                        $display("FAIL big_center: h=%0d x=%h, want h=160 x=00000000", cur.h, cur.x);
                    end
                end
                if (nbeat == BW * BH - 1) begin
                    n_cmp++;
                    if (cur.h !== 16'd319 || cur.v !== 16'd179 || cur.x !== 32'h431F_0000 || cur.y !== 32'hC2B2_0000) begin
                        n_bad++;
                        $display("FAIL big_last: h=%0d v=%0d x=%h y=%h, want 319 179 431F0000 C2B20000", cur.h, cur.v, cur.x, cur.y);
                    end
                end
                nbeat++;
                last_cyc = cyc;
            end
        end
        n_cmp++;
        if (nbeat != BW * BH) begin
            n_bad++;
            $display("FAIL big_beat_count: got %0d, want %0d", nbeat, BW * BH);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
            n_bad++;
            $display("FAIL big_done: pulses=%0d at cycle %0d, want 1 pulse at cycle %0d", done_cnt, done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_small_frame();
        logic [31:0] xs [4];
        xs[0] = 32'hC000_0000; xs[1] = 32'hBF80_0000; xs[2] = 32'h0000_0000; xs[3] = 32'h3F80_0000;
        build_small_exp();
        collect_small(0, 1'b0, 200);
        n_cmp++;
        if (got_q.size() != SW * SH || c_timeout) begin
            n_bad++;
            $display("FAIL small_count: got %0d beats (timeout=%b), want %0d", got_q.size(), c_timeout, SW * SH);
        end
        for (int i = 0; i < got_q.size() && i < SW * SH; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL small_model[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
            n_cmp++;
            if (got_q[i].x !== xs[i % 4] || got_q[i].y !== ((i < 4) ? 32'h3F80_0000 : 32'h0) || got_q[i].z !== 32'hBF80_0000) begin
                n_bad++;
                $display("FAIL small_const[%0d]: x=%h y=%h z=%h", i, got_q[i].x, got_q[i].y, got_q[i].z);
            end
        end
        n_cmp++;
        if (c_first_valid != 2) begin
            n_bad++;
            $display("FAIL small_latency: got %0d, want 2", c_first_valid);
        end
        n_cmp++;
        if (c_done_cnt != 1 || c_done_cyc != c_last_xfer + 1 || c_busy_bad != 0) begin
            n_bad++;
            $display("FAIL small_done: pulses=%0d at %0d busy_errs=%0d, want 1 at %0d and 0", c_done_cnt, c_done_cyc, c_busy_bad, c_last_xfer + 1);
        end
    endtask

    task automatic test_stall();
        build_small_exp();
        collect_small(1, 1'b0, 400);
        n_cmp++;
        if (got_q.size() != SW * SH || c_timeout) begin
            n_bad++;
            $display("FAIL stall_count: got %0d beats (timeout=%b), want %0d", got_q.size(), c_timeout, SW * SH);
        end
        for (int i = 0; i < got_q.size() && i < SW * SH; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL stall_seq[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (c_stall_viol != 0) begin
            n_bad++;
            $display("FAIL stall_stable: %0d changes while stalled, want 0", c_stall_viol);
        end
        n_cmp++;
        if (c_done_cnt != 1 || c_done_cyc != c_last_xfer + 1) begin
            n_bad++;
            $display("FAIL stall_done: pulses=%0d at %0d, want 1 at %0d", c_done_cnt, c_done_cyc, c_last_xfer + 1);
        end
    endtask

    task automatic test_start_hold();
        build_small_exp();
        collect_small(0, 1'b1, 200);
        n_cmp++;
        if (got_q.size() != SW * SH || c_done_cnt != 1 || c_timeout) begin
            n_bad++;
            $display("FAIL hold_start: beats=%0d done=%0d timeout=%b, want %0d beats and 1 done", got_q.size(), c_done_cnt, c_timeout, SW * SH);
        end
        for (int i = 0; i < got_q.size() && i < SW * SH; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL hold_seq[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        collect_small(0, 1'b0, 200);
        n_cmp++;
        if (got_q.size() != SW * SH || got_q[0] !== exp_q[0] || c_first_valid != 2) begin
            n_bad++;
            $display("FAIL restart_after_done: beats=%0d first=%h latency=%0d, want %0d beats first=%h latency 2",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : beat_t'('x), c_first_valid, SW * SH, exp_q[0]);
        end
    endtask

    task automatic test_mid_reset();
        int beats = 0;
        int cyc = 0;
        int dones = 0;
        int valids = 0;
        build_small_exp();
        start_s = 1'b1;
        if_s.ready_in = 1'b1;
        while (beats < 3 && cyc < 50) begin
            @(negedge clk_in);
            cyc++;
            start_s = 1'b0;
            if (if_s.valid_out) beats++;
        end
        rst_s = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if ({if_s.valid_out, busy_s, done_s, if_s.dir_x, if_s.dir_y, if_s.dir_z, if_s.hcount_out, if_s.vcount_out} !== '0 || beats != 3) begin
            n_bad++;
            $display("FAIL mid_reset_zero: beats=%0d valid=%b busy=%b done=%b x=%h y=%h z=%h h=%0d v=%0d, want 3 beats then all zero",
                     beats, if_s.valid_out, busy_s, done_s, if_s.dir_x, if_s.dir_y, if_s.dir_z, if_s.hcount_out, if_s.vcount_out);
        end
        rst_s = 1'b1;
        repeat (6) begin
            @(negedge clk_in);
            if (done_s) dones++;
            if (if_s.valid_out || busy_s) valids++;
        end
        n_cmp++;
        if (dones != 0 || valids != 0) begin
            n_bad++;
            $display("FAIL mid_reset_quiet: done pulses=%0d active cycles=%0d, want 0 and 0", dones, valids);
        end
        collect_small(0, 1'b0, 200);
        n_cmp++;
        if (got_q.size() != SW * SH || got_q[0] !== exp_q[0] || c_first_valid != 2 || c_done_cnt != 1) begin
            n_bad++;
            $display("FAIL mid_reset_rescan: beats=%0d first=%h latency=%0d done=%0d, want %0d beats first=%h latency 2 done 1",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : beat_t'('x), c_first_valid, c_done_cnt, SW * SH, exp_q[0]);
        end
    endtask

    task automatic test_ready_low_start();
        build_small_exp();
        collect_small(2, 1'b0, 200);
        n_cmp++;
        if (got_q.size() != SW * SH || c_timeout) begin
            n_bad++;
            $display("FAIL rdylow_count: got %0d beats (timeout=%b), want %0d", got_q.size(), c_timeout, SW * SH);
        end
        for (int i = 0; i < got_q.size() && i < SW * SH; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL rdylow_seq[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (c_first_valid != 2 || c_stall_viol != 0) begin
            n_bad++;
            $display("FAIL rdylow_hold: latency=%0d stall changes=%0d, want 2 and 0", c_first_valid, c_stall_viol);
        end
        n_cmp++;
        if (c_first_xfer != 8 || c_last_xfer != 8 + SW * SH - 1) begin
            n_bad++;
            $display("FAIL rdylow_contig: transfers %0d..%0d, want 8..%0d", c_first_xfer, c_last_xfer, 8 + SW * SH - 1);
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_stall();
        test_start_hold();
        test_mid_reset();
        test_ready_low_start();
        test_default_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ray_dir_gen.md
Name: ray_dir_gen

Overview:
- Upstream feeder of the vector normalize stage.
- On start, scans every pixel of a WIDTH x HEIGHT frame in raster order and emits one unnormalized camera-ray direction per pixel, as three IEEE-754 single-precision words: (h - WIDTH/2, HEIGHT/2 - v, -FOCAL).
- Signed-integer to float32 conversion is done in plain RTL with no IP cores. The output carries a valid/ready handshake plus the pixel coordinates, so downstream consumers can tag results.

Parameters:
- WIDTH, 320, horizontal pixel count (even, 2..32768).
- HEIGHT, 180, vertical pixel count (even, 2..32768).
- FOCAL, 256, focal distance (1..32767); emitted as -FOCAL on z.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-low.
- start_in  input  1  begin a frame scan; sampled only in IDLE.
- ready_in  input  1  downstream accepts the output this cycle.
- dir_x  output  32  float32 of h - WIDTH/2.
- dir_y  output  32  float32 of HEIGHT/2 - v.
- dir_z  output  32  float32 of -FOCAL.
- hcount_out  output  16  pixel column of the current output.
- vcount_out  output  16  pixel row of the current output.
- valid_out  output  1  output words valid.
- busy_out  output  1  high from start acceptance until the last beat is accepted.
- done_out  output  1  one-cycle pulse on acceptance of the last pixel.

Behaviour:
- Reset (rst_in==0 at a clk_in edge):
  - FSM returns to IDLE.
  - Counters are cleared; all pipeline valids are cleared.
  - Every output goes to 0: valid_out, busy_out, done_out, dir_*, hcount_out, vcount_out.
  - Reset mid-scan aborts the frame with no done pulse. The first post-reset scan restarts at (0,0).
- FSM:
  - IDLE: start_in=1 -> RUN. Counters are set to h=0, v=0 and busy_out=1 in the same edge.
  - RUN: issue one pixel per advancing cycle.
    - After the pixel (WIDTH-1, HEIGHT-1) is issued -> DRAIN.
  - DRAIN: wait until the pipeline is empty and the last beat is accepted. Then -> IDLE with busy_out=0 and done_out=1 for exactly that one cycle.
  - start_in is ignored outside IDLE.
- Pipeline:
  - Stage 0: counter plus signed 17-bit integers.
  - Stage 1: leading-one detect and normalize.
  - Stage 2: output register.
  - Latency is 2 cycles from issue to valid_out when unstalled. Sustained throughput is 1 pixel/cycle.
- Handshake:
  - advance = ready_in | ~valid_out.
  - When advance=0, all stages and the counters hold.
  - While valid_out=1 and ready_in=0, dir_*, hcount_out and vcount_out stay stable.
  - A beat transfers on valid_out & ready_in.
- Counter:
  - h increments per issue.
  - At h==WIDTH-1, h wraps to 0 and v increments.
  - The counters never issue beyond (WIDTH-1, HEIGHT-1).
- int->float conversion (exact; |n| <= 32768 fits in 24 mantissa bits):
  - n==0 -> 32'h00000000 (+0).
  - Otherwise: sign = n<0; m = |n|; e = index of the MSB of m; exponent = 127+e; mantissa = (m << (23-e))[22:0].
  - No rounding is required.
- done_out and the final valid beat are not simultaneous: done_out is asserted the cycle after the last transfer.

Test Plan:
- Defaults, ready_in=1, start pulse:
  - First beat 2 cycles after start acceptance: (h=0, v=0), dir_x=0xC3200000 (-160), dir_y=0x42B40000 (90), dir_z=0xC3800000 (-256).
  - Beat (160, 0): dir_x=0x00000000.
  - Beat (319, 179): dir_x=0x431F0000 (159), dir_y=0xC2B20000 (-89).
  - Exactly 57600 beats, then done_out is a single-cycle pulse and busy_out falls.
- WIDTH=4, HEIGHT=2, FOCAL=1, ready_in=1:
  - Beats in order (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(3,1).
  - dir_x sequence 0xC0000000, 0xBF800000, 0, 0x3F800000.
  - dir_y = 0x3F800000 for row 0 and 0x00000000 for row 1.
  - dir_z = 0xBF800000.
- WIDTH=4, HEIGHT=2, ready_in toggled randomly and held low 5 cycles mid-beat:
  - Outputs are stable while stalled.
  - No beat is dropped or duplicated; the sequence is identical to the previous test.
- start_in held high during RUN and during DRAIN: no restart, still exactly WIDTH*HEIGHT beats. A start in IDLE after done begins a fresh scan at (0,0).
- rst_in driven low at beat 3 of a scan:
  - Next cycle all outputs are 0 and there is no done pulse.
  - After rst_in=1 and a start, the first beat is (0,0).
- ready_in=0 from before start:
  - The first beat appears and holds. The pipeline fills to at most 3 pixels; the counters stop at h=2.
  - On ready_in=1, beats continue contiguously.
